// File: rtl/obi_mem_responder.sv
// Single-port OBI memory responder: programmable grant latency, byte-enabled writes,
// one-cycle registered responses with an error flag for out-of-range accesses.
module obi_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned GNT_WAIT    = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SIZE_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [3:0]    wcnt;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          accept;

    // Subtracting the base lets addresses below BASE_ADDR wrap high and fail the bound.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = {1'b0, offset} < SIZE_BYTES;
    assign idx      = offset[AW+1:2];

    assign gnt_o  = req_i && (wcnt == 4'(GNT_WAIT));
    assign accept = req_i && gnt_o && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt <= '0;
        end else if (req_i && !gnt_o) begin
            wcnt <= wcnt + 4'd1;
        end else begin
            wcnt <= '0;
        end
    end

    // NOTE: memory has no reset branch -- contents must survive reset, and a reset
    // on a large array would also prevent RAM inference.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so a read accepted right after a
    // write to the same word sees the value committed at the earlier edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= accept;
            err_o    <= accept && !in_range;
            rdata_o  <= (accept && !we_i && in_range) ? mem[idx] : '0;
        end
    end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; memory size in 32-bit words, power of two, at least 2.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000; byte address of word 0, aligned to DEPTH_WORDS*4.
REQ-003 SHALL have parameter GNT_WAIT, default 0; wait cycles inserted before each grant, range 0..15.
REQ-004 SHALL have port clk_i, input, 1 bit; the single clock, rising edge active.
REQ-005 SHALL have port rst_ni, input, 1 bit; reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_i, input, 1 bit; initiator address-phase request.
REQ-007 SHALL have port gnt_o, output, 1 bit; address-phase grant.
REQ-008 SHALL have port addr_i, input, 32 bits; byte address; bits [1:0] are ignored.
REQ-009 SHALL have port we_i, input, 1 bit; 1 = write, 0 = read.
REQ-010 SHALL have port be_i, input, 4 bits; byte enables, bit n selects wdata_i[8n+7:8n].
REQ-011 SHALL have port wdata_i, input, 32 bits; write data.
REQ-012 SHALL have port rvalid_o, output, 1 bit; response-phase valid.
REQ-013 SHALL have port rdata_o, output, 32 bits; read data, qualified by rvalid_o.
REQ-014 SHALL have port err_o, output, 1 bit; response error, qualified by rvalid_o.

Function
REQ-015 SHALL accept a transfer on every rising edge where req_i=1 and gnt_o=1; no other cycle accepts a transfer.
REQ-016 SHALL keep a wait counter wcnt (4 bits).
- wcnt increments each cycle req_i=1 and gnt_o=0.
- wcnt clears to 0 on acceptance or when req_i=0.
REQ-017 SHALL drive gnt_o combinationally as req_i AND (wcnt == GNT_WAIT).
- With GNT_WAIT=0, grant is in the same cycle as the request.
- Back-to-back acceptances every cycle are allowed.
REQ-018 SHALL compute the in-range condition as: (addr_i - BASE_ADDR) unsigned < DEPTH_WORDS*4. The word index is bits [log2(DEPTH_WORDS)+1:2] of the difference.
REQ-019 SHALL, on an accepted in-range write, update only the bytes selected by be_i at the edge of acceptance.
- be_i=4'b0000 changes nothing and is not an error.
REQ-020 SHALL, on an accepted in-range read, register the addressed word so that it is presented on rdata_o on the next cycle.
REQ-021 SHALL assert rvalid_o for exactly one cycle, on the cycle after each acceptance, for both reads and writes.
- Responses SHALL be in acceptance order.
- There SHALL be no response backpressure.
REQ-022 SHALL set rdata_o=0 for write responses and for error responses.
REQ-023 SHALL, on an accepted out-of-range transfer, leave memory unmodified and respond with err_o=1 and rdata_o=0.
REQ-024 SHALL hold err_o=0 and rdata_o=0 on cycles where rvalid_o=0.
REQ-025 SHALL return, for a read accepted the cycle after a write to the same word, the newly written data.
REQ-026 SHALL NOT require address-phase signals to be checked for stability while waiting for a grant. The sampled values are those present at acceptance.

Reset
REQ-027 SHALL, while rst_ni=0, force rvalid_o=0, err_o=0, rdata_o=0 and wcnt=0. Consequently gnt_o=0 if GNT_WAIT>0.
REQ-028 SHALL NOT reset memory contents.
REQ-029 SHALL drop any response pending when reset asserts; no rvalid_o pulse follows reset release for that transfer.
REQ-030 SHALL restart the wait count from 0 after reset release if req_i is held across reset.
REQ-031 SHALL NOT accept any transfer while rst_ni=0.

Verification
REQ-032 GNT_WAIT=0: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 the next cycle. Required: gnt_o=1 in both request cycles; rvalid pulses on cycles 2 and 3; second response rdata_o=0xDEADBEEF, err_o=0.
REQ-033 Byte enables: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=4'b0101, then read 0x20. Required: rdata_o=0x11BB33DD.
REQ-034 GNT_WAIT=3: hold req_i. Required: gnt_o rises on the 4th cycle of the request; rvalid_o on the 5th cycle; two back-to-back requests each wait 3 cycles.
REQ-035 Out of range (DEPTH_WORDS=1024, BASE_ADDR=0): write to 0x1000, then read 0x0. Required: write response err_o=1, rdata_o=0; word 0 unchanged.
REQ-036 Streaming: 8 consecutive reads with req_i held high and GNT_WAIT=0. Required: 8 consecutive rvalid_o cycles in order with correct data.
REQ-037 Reset mid-operation: assert rst_ni=0 in the cycle after an accepted read. Required: no rvalid_o pulse, all outputs 0, memory contents retained after release.
